// File: rtl/npc_seq_pkg.sv
// npc_seq_pkg: shared definitions for the NPC execution sequencer.
//   - seq_state_e : FSM state encoding (visible on state_dbg)
//   - OP_*        : opcode values the sequencer reacts to
//   - DEF_MAX_WAIT: default bus-wait limit
package npc_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_WAIT_I = 3'd2,
        S_DECODE = 3'd3,
        S_EXEC   = 3'd4,
        S_MEM    = 3'd5,
        S_WB     = 3'd6,
        S_HALT   = 3'd7
    } seq_state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam int DEF_MAX_WAIT = 255;

endpackage

// File: rtl/npc_wait_timer.sv
// npc_wait_timer: bus-wait cycle counter.
//   clk, rst : clock, async active-high reset
//   clr      : synchronous clear (wins over en)
//   en       : count up by one this cycle
//   expire   : count has reached MAX_WAIT
module npc_wait_timer #(
    parameter int WAIT_W   = 8,
    parameter int MAX_WAIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [WAIT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       cnt <= '0;
        else if (clr)  cnt <= '0;
        else if (en)   cnt <= cnt + WAIT_W'(1);
    end

    assign expire = (cnt == WAIT_W'(MAX_WAIT));

endmodule

// File: rtl/npc_exec_sequencer.sv
// npc_exec_sequencer: multi-cycle control FSM for the NPC core.
// Steps IDLE -> FETCH -> WAIT_I -> DECODE -> EXEC -> [MEM] -> WB -> FETCH,
// halting on ebreak (DECODE) or on a bus wait exceeding MAX_WAIT.
//   in : clk, rst (async high), opcode, reg_wr_dec, imem_gnt, imem_rvalid, dmem_done
//   out: imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we  (enables / requests)
//        halt, bus_err (sticky), state_dbg, retired (WB count)
module npc_exec_sequencer
    import npc_seq_pkg::*;
#(
    parameter int WAIT_W   = 8,
    parameter int MAX_WAIT = DEF_MAX_WAIT,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic             reg_wr_dec,
    input  logic             imem_gnt,
    input  logic             imem_rvalid,
    input  logic             dmem_done,
    output logic             imem_req,
    output logic             ir_we,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             rf_we,
    output logic             pc_we,
    output logic             halt,
    output logic             bus_err,
    output logic [2:0]       state_dbg,
    output logic [CNT_W-1:0] retired
);

    seq_state_e state, state_nx;
    logic       timeout;
    logic       wait_clr, wait_en, wait_exp;
    logic       is_store;

    assign is_store = (opcode == OP_STORE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Handshake is tested before the expiry so a grant/valid/done landing
    // in the limit cycle completes normally.
    always_comb begin
        state_nx = state;
        timeout  = 1'b0;
        case (state)
            S_IDLE:   state_nx = S_FETCH;
            S_FETCH: begin
                if (imem_gnt)      state_nx = S_WAIT_I;
                else if (wait_exp) begin state_nx = S_HALT; timeout = 1'b1; end
            end
            S_WAIT_I: begin
                if (imem_rvalid)   state_nx = S_DECODE;
                else if (wait_exp) begin state_nx = S_HALT; timeout = 1'b1; end
            end
            S_DECODE: state_nx = (opcode == OP_SYSTEM) ? S_HALT : S_EXEC;
            S_EXEC:   state_nx = (opcode == OP_LOAD || is_store) ? S_MEM : S_WB;
            S_MEM: begin
                if (dmem_done)     state_nx = S_WB;
                else if (wait_exp) begin state_nx = S_HALT; timeout = 1'b1; end
            end
            S_WB:     state_nx = S_FETCH;
            default:  state_nx = S_HALT;
        endcase
    end

    // Counter restarts on any state change and only runs while parked
    // in one of the three bus-wait states.
    assign wait_clr = (state_nx != state);
    assign wait_en  = (state == S_FETCH) || (state == S_WAIT_I) || (state == S_MEM);

    npc_wait_timer #(
        .WAIT_W   (WAIT_W),
        .MAX_WAIT (MAX_WAIT)
    ) u_wait (
        .clk    (clk),
        .rst    (rst),
        .clr    (wait_clr),
        .en     (wait_en),
        .expire (wait_exp)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          bus_err <= 1'b0;
        else if (timeout) bus_err <= 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                retired <= '0;
        else if (state == S_WB) retired <= retired + CNT_W'(1);
    end

    // Moore decodes; ir_we alone also looks at imem_rvalid so the IR
    // captures the word in the cycle it is on the bus.
    assign imem_req  = (state == S_FETCH);
    assign ir_we     = (state == S_WAIT_I) && imem_rvalid;
    assign dmem_req  = (state == S_MEM);
    assign dmem_we   = (state == S_MEM) && is_store;
    assign pc_we     = (state == S_WB);
    assign rf_we     = (state == S_WB) && reg_wr_dec && !is_store;
    assign halt      = (state == S_HALT);
    assign state_dbg = state;

endmodule

// File: tb/tb_npc_exec_sequencer.sv
module tb_npc_exec_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  opcode = 7'b0010011;
    logic        reg_wr_dec = 1'b1;
    logic        imem_gnt = 1'b1, imem_rvalid = 1'b1, dmem_done = 1'b1;
    logic        imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, halt, bus_err;
    logic [2:0]  state_dbg;
    logic [31:0] retired;

    int n_chk = 0;
    int n_err = 0;

    localparam logic [6:0] ADDI = 7'b0010011, LOAD = 7'b0000011,
                           STORE = 7'b0100011, EBRK = 7'b1110011;

    npc_exec_sequencer #(.WAIT_W(8), .MAX_WAIT(4), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .reg_wr_dec(reg_wr_dec),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .dmem_done(dmem_done),
        .imem_req(imem_req), .ir_we(ir_we), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .rf_we(rf_we), .pc_we(pc_we), .halt(halt), .bus_err(bus_err),
        .state_dbg(state_dbg), .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // advance one edge; sample 1 time unit later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".outs"}, {24'd0, imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, halt, bus_err}, 32'd0);
        chk({tag, ".state"}, {29'd0, state_dbg}, 32'd0);
        chk({tag, ".retired"}, retired, 32'd0);
    endtask

    initial begin
        int cyc;
        // ---------------- reset state ----------------
        #1;
        chk_zero("rst");
        step(); step();
        rst = 1'b0;
        #1;
        chk("addi.idle", {29'd0, state_dbg}, 0);

        // ---------------- addi, zero-wait ----------------
        begin
            logic [2:0] exp_st [6];
            exp_st = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd1};
            for (int i = 0; i < 6; i++) begin
                step();
                chk($sformatf("addi.st%0d", i), {29'd0, state_dbg}, {29'd0, exp_st[i]});
                chk($sformatf("addi.rf%0d", i), {31'd0, rf_we}, (exp_st[i] == 3'd6) ? 1 : 0);
                chk($sformatf("addi.pc%0d", i), {31'd0, pc_we}, (exp_st[i] == 3'd6) ? 1 : 0);
                if (exp_st[i] == 3'd1) chk("addi.ireq", {31'd0, imem_req}, 1);
                if (exp_st[i] == 3'd2) chk("addi.irwe", {31'd0, ir_we}, 1);
            end
            chk("addi.retired", retired, 1);
        end

        // ---------------- store, done delayed 3 ----------------
        opcode = STORE; reg_wr_dec = 1'b0; dmem_done = 1'b0;
        cyc = 1;                       // currently in FETCH
        step(); cyc++; chk("st.waiti", {29'd0, state_dbg}, 2);
        step(); cyc++; chk("st.dec", {29'd0, state_dbg}, 3);
        step(); cyc++; chk("st.exec", {29'd0, state_dbg}, 4);
        for (int k = 0; k < 4; k++) begin
            step(); cyc++;
            if (k == 3) dmem_done = 1'b1;
            #1;
            chk($sformatf("st.mem%0d", k), {29'd0, state_dbg}, 5);
            chk($sformatf("st.dreq%0d", k), {31'd0, dmem_req}, 1);
            chk($sformatf("st.dwe%0d", k), {31'd0, dmem_we}, 1);
        end
        step(); cyc++;
        dmem_done = 1'b0;
        chk("st.wb", {29'd0, state_dbg}, 6);
        chk("st.rf", {31'd0, rf_we}, 0);
        chk("st.pc", {31'd0, pc_we}, 1);
        chk("st.dreq_wb", {31'd0, dmem_req}, 0);
        step();
        chk("st.fetch", {29'd0, state_dbg}, 1);
        chk("st.cycles", cyc, 9);
        chk("st.retired", retired, 2);

        // ---------------- load, gnt delayed 2, rvalid after 1 wait ----------------
        opcode = LOAD; reg_wr_dec = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b1; dmem_done = 1'b1;
        #1;
        chk("ld.stray_fetch", {31'd0, ir_we}, 0);
        imem_rvalid = 1'b0;
        step();
        chk("ld.fetch2", {29'd0, state_dbg}, 1);
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        #1;
        chk("ld.waiti", {29'd0, state_dbg}, 2);
        chk("ld.irwe_lo", {31'd0, ir_we}, 0);
        step();
        imem_rvalid = 1'b1;
        #1;
        chk("ld.irwe_hi", {31'd0, ir_we}, 1);
        step();
        chk("ld.dec", {29'd0, state_dbg}, 3);
        chk("ld.stray_dec", {31'd0, ir_we}, 0);
        step();
        chk("ld.exec", {29'd0, state_dbg}, 4);
        step();
        chk("ld.mem", {29'd0, state_dbg}, 5);
        chk("ld.dwe", {31'd0, dmem_we}, 0);
        chk("ld.dreq", {31'd0, dmem_req}, 1);
        step();
        chk("ld.wb", {29'd0, state_dbg}, 6);
        chk("ld.rf", {31'd0, rf_we}, 1);
        step();
        chk("ld.retired", retired, 3);

        // ---------------- fetch: grant in the limit cycle wins ----------------
        opcode = ADDI; imem_gnt = 1'b0; imem_rvalid = 1'b1;
        for (int k = 0; k < 4; k++) step();
        chk("lim.still_fetch", {29'd0, state_dbg}, 1);
        imem_gnt = 1'b1;
        step();
        chk("lim.waiti", {29'd0, state_dbg}, 2);
        chk("lim.no_err", {31'd0, bus_err}, 0);
        imem_gnt = 1'b0;
        step(); step(); step();            // DECODE, EXEC, WB
        chk("lim.wb", {29'd0, state_dbg}, 6);
        step();
        chk("lim.fetch", {29'd0, state_dbg}, 1);

        // ---------------- fetch timeout ----------------
        for (int k = 0; k < 4; k++) step();
        chk("to.fetch5", {29'd0, state_dbg}, 1);
        chk("to.ireq", {31'd0, imem_req}, 1);
        step();
        chk("to.halt_st", {29'd0, state_dbg}, 7);
        chk("to.halt", {31'd0, halt}, 1);
        chk("to.bus_err", {31'd0, bus_err}, 1);
        imem_gnt = 1'b1;
        step(); step();
        chk("to.sticky", {29'd0, state_dbg, bus_err, halt} , {29'd0, 3'd7, 1'b1, 1'b1} >> 0);
        chk("to.ireq_off", {31'd0, imem_req}, 0);
        chk("to.retired", retired, 4);

        // ---------------- ebreak ----------------
        rst = 1'b1; #1;
        chk_zero("rst2");
        step();
        rst = 1'b0;
        opcode = EBRK; imem_gnt = 1'b1; imem_rvalid = 1'b1;
        step(); step(); step();
        chk("eb.dec", {29'd0, state_dbg}, 3);
        step();
        chk("eb.halt_st", {29'd0, state_dbg}, 7);
        chk("eb.halt", {31'd0, halt}, 1);
        chk("eb.bus_err", {31'd0, bus_err}, 0);
        step(); step();
        chk("eb.sticky", {31'd0, halt}, 1);
        chk("eb.pc", {31'd0, pc_we}, 0);
        chk("eb.rf", {31'd0, rf_we}, 0);
        chk("eb.retired", retired, 0);
        rst = 1'b1; #1;
        chk_zero("rst3");
        step();

        // ---------------- async reset mid-MEM ----------------
        rst = 1'b0; opcode = ADDI; dmem_done = 1'b0;
        for (int k = 0; k < 6; k++) step();
        chk("ar.retired1", retired, 1);
        opcode = LOAD;
        step(); step(); step(); step();    // WAIT_I, DECODE, EXEC, MEM
        step();
        chk("ar.mem", {29'd0, state_dbg}, 5);
        chk("ar.dreq_hi", {31'd0, dmem_req}, 1);
        #2;                                // mid-cycle, no clock edge
        rst = 1'b1;
        #1;
        chk("ar.dreq_lo", {31'd0, dmem_req}, 0);
        chk("ar.state", {29'd0, state_dbg}, 0);
        chk("ar.retired", retired, 0);
        step();
        rst = 1'b0;
        #1;
        chk("ar.idle", {29'd0, state_dbg}, 0);
        step();
        chk("ar.fetch", {29'd0, state_dbg}, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/npc_exec_sequencer.md
Name: npc_exec_sequencer

Overview:
- Multi-cycle control sequencer for the NPC core.
- Steps each instruction through fetch, decode, execute, memory and write-back, and handshakes with the instruction and data memory ports.
- Gates the PC, IR and register-file write enables, and sits between the instruction decoder (opcode, RegWr) and the datapath registers.
- Detects bus stalls and halts the core on ebreak or a bus timeout.

Parameters:
- WAIT_W, 8: width of the bus-wait cycle counter.
- MAX_WAIT, 255: wait cycles allowed in FETCH, WAIT_I or MEM before a bus error; must be < 2^WAIT_W.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- opcode  in  7  IR[6:0]; valid from DECODE onward.
- reg_wr_dec  in  1  RegWr from the decoder for the current IR.
- imem_gnt  in  1  instruction memory accepted the request.
- imem_rvalid  in  1  instruction word valid on the fetch data bus.
- dmem_done  in  1  data access complete (load data valid, or store committed).
- imem_req  out  1  fetch request.
- ir_we  out  1  load the IR from the fetch data bus.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  data request is a store.
- rf_we  out  1  register-file write enable.
- pc_we  out  1  PC update enable; the next-PC mux is chosen by the datapath Branch select.
- halt  out  1  core halted; sticky.
- bus_err  out  1  halt was caused by a timeout; sticky.
- state_dbg  out  3  current state encoding.
- retired  out  CNT_W  count of instructions completed via WB.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, wait counter=0, retired=0, bus_err=0.
  - Every output reads 0; state_dbg=3'd0.
- State encoding: IDLE=0, FETCH=1, WAIT_I=2, DECODE=3, EXEC=4, MEM=5, WB=6, HALT=7.
- Output timing:
  - All outputs are Moore decodes of the registered state, except ir_we = (state==WAIT_I) & imem_rvalid.
- Transitions:
  - IDLE: -> FETCH unconditionally. Exactly one cycle after reset release.
  - FETCH: imem_req=1. -> WAIT_I when imem_gnt, else stay.
  - WAIT_I: -> DECODE on imem_rvalid. ir_we pulses in that same cycle.
  - DECODE: 1 cycle. opcode==7'b1110011 -> HALT; else -> EXEC.
  - EXEC: 1 cycle. opcode 7'b0000011 (load) or 7'b0100011 (store) -> MEM; else -> WB.
  - MEM: dmem_req=1, dmem_we=(opcode==store). -> WB on dmem_done, else stay.
  - WB: 1 cycle, then -> FETCH.
    - pc_we=1; retired increments by 1 (wraps modulo 2^CNT_W).
    - rf_we = reg_wr_dec & (opcode!=store).
  - HALT: halt=1; no other enables asserted. Left only by reset.
- Unknown opcodes follow the EXEC -> WB path. rf_we is whatever the decoder gives via reg_wr_dec.
- Latency:
  - Non-memory instruction with zero-wait memory: 5 cycles (FETCH..WB).
  - Load/store with zero-wait memory: 6 cycles.
  - Each extra wait cycle adds 1.
- Wait counter:
  - Cleared on every state change.
  - Increments each cycle the FSM stays in FETCH, WAIT_I or MEM.
  - When it equals MAX_WAIT and the awaited handshake is low: bus_err<=1 and -> HALT next edge.
  - Handshake arriving in the same cycle the limit is hit wins: normal transition, no error.
- Handshake inputs arriving in states that do not await them are ignored. A stray imem_rvalid outside WAIT_I must not pulse ir_we.
- Asynchronous reset mid-MEM or mid-WAIT_I:
  - dmem_req and imem_req drop combinationally with state.
  - Any pending memory transaction is abandoned; the memory side tolerates request withdrawal.
- halt and bus_err stay set until rst.

Decomposition:
- Package npc_seq_pkg holds:
  - state enum/localparams.
  - opcode constants OP_LOAD=7'b0000011, OP_STORE=7'b0100011, OP_SYSTEM=7'b1110011.
  - default MAX_WAIT.
- One natural sub-module, npc_wait_timer: WAIT_W counter with clear and enable inputs, and an expire output (count==MAX_WAIT).
- The FSM and output decode stay in npc_exec_sequencer.

Test Plan:
- Reset then addi (0010011), reg_wr_dec=1, gnt/rvalid/done tied 1 -> state_dbg 0,1,2,3,4,6,1; rf_we=1 and pc_we=1 only in cycle 6 of that sequence; retired=1.
- Store (0100011), reg_wr_dec=0, dmem_done delayed 3 cycles -> dmem_req=1, dmem_we=1 for 4 cycles; WB has rf_we=0, pc_we=1; total 9 cycles FETCH->FETCH.
- Load (0000011), imem_gnt delayed 2 cycles and imem_rvalid after 1 wait -> ir_we single pulse coincident with rvalid; dmem_we=0; rf_we=1 in WB; retired increments by exactly 1.
- Fetch timeout with MAX_WAIT=4, imem_gnt held 0 -> bus_err=1, halt=1 after 5 cycles in FETCH; further gnt ignored. Repeat with gnt rising in the limit cycle -> no error, -> WAIT_I.
- ebreak (1110011) -> DECODE -> HALT; halt=1 sticky; no pc_we/rf_we; retired unchanged. rst pulse -> all outputs 0, state_dbg=0.
- Async rst asserted mid-MEM with dmem_req=1 -> dmem_req=0 immediately (same cycle); retired=0; restarts at FETCH one cycle after release.
